// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the registered ALU.
//   Op field bit positions, logic sub-op codes and the pipeline FSM state type.
//   Multiply support in alu_pipe is enabled by defining ALU_MUL_EN.
package alu_pkg;

   localparam int unsigned OP_W      = 5;
   localparam int unsigned OP_MUL    = 4;  // multiply request (ALU_MUL_EN builds only)
   localparam int unsigned OP_LOGIC  = 3;  // 1 = logic group, 0 = arithmetic group
   localparam int unsigned OP_INV_Y  = 2;  // arith: add ~y
   localparam int unsigned OP_PASS_Y = 1;  // arith: add y
   localparam int unsigned OP_CIN    = 0;  // arith: carry in

   localparam logic [1:0] LOG_AND = 2'b00;
   localparam logic [1:0] LOG_OR  = 2'b01;
   localparam logic [1:0] LOG_XOR = 2'b10;
   localparam logic [1:0] LOG_NOT = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational WIDTH-bit arithmetic/logic datapath.
//   x_i, y_i  : operands
//   op_i      : op[3:0] select (arith when op[3]=0, logic when op[3]=1)
//   res_o     : WIDTH-bit result (modulo 2^WIDTH)
//   c_out_o   : carry out of the MSB for arithmetic, 0 for logic
//   ovf_o     : signed overflow for arithmetic, 0 for logic
module alu_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] x_i,
   input  logic [WIDTH-1:0] y_i,
   input  logic [3:0]       op_i,
   output logic [WIDTH-1:0] res_o,
   output logic             c_out_o,
   output logic             ovf_o
);

   logic [WIDTH-1:0] b;
   logic [WIDTH:0]   sum;

   always_comb begin
      // b selects 0, y, ~y or all-ones (~y | y) from the two enable bits
      b   = (op_i[OP_INV_Y] ? ~y_i : '0) | (op_i[OP_PASS_Y] ? y_i : '0);
      sum = {1'b0, x_i} + {1'b0, b} + (WIDTH+1)'(op_i[OP_CIN]);

      res_o   = sum[WIDTH-1:0];
      c_out_o = sum[WIDTH];
      ovf_o   = (x_i[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != x_i[WIDTH-1]);

      if (op_i[OP_LOGIC]) begin
         c_out_o = 1'b0;
         ovf_o   = 1'b0;
         case (op_i[1:0])
            LOG_AND: res_o = x_i & y_i;
            LOG_OR:  res_o = x_i | y_i;
            LOG_XOR: res_o = x_i ^ y_i;
            default: res_o = ~x_i;
         endcase
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshake on both sides.
//   clk, reset        : single clock, synchronous active-high reset
//   in_valid/in_ready : operand handshake; x, y, op captured on transfer
//   out_valid/out_ready : result handshake; outputs held stable until accepted
//   result, result_hi : result (low half) and high half of a product (0 otherwise)
//   c_out, zero, neg, ovf : status flags registered with the result
// Optional feature: define ALU_MUL_EN to enable op[4] = iterative unsigned
//   shift-add multiply (WIDTH iterations in BUSY). Without it op[4] is ignored
//   and result_hi is tied to 0.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [OP_W-1:0]  op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             c_out,
   output logic             zero,
   output logic             neg,
   output logic             ovf
);

   state_t           state_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] result_q;
   logic             c_out_q;
   logic             zero_q;
   logic             neg_q;
   logic             ovf_q;

   logic [WIDTH-1:0] core_res;
   logic             core_c;
   logic             core_v;
   logic             accept;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .x_i     (x),
      .y_i     (y),
      .op_i    (op[3:0]),
      .res_o   (core_res),
      .c_out_o (core_c),
      .ovf_o   (core_v)
   );

   // HOLD may drain and refill in the same clock when the consumer is ready
   assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
   assign accept   = in_valid && in_ready;

`ifdef ALU_MUL_EN
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0]   mcand_q;
   logic [WIDTH-1:0]   result_hi_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [2*WIDTH-1:0] prod_d;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH:0]     partial;

   // prod_q holds {accumulator, remaining multiplier bits}; each step adds the
   // multiplicand when the current multiplier LSB is set, then shifts right.
   always_comb begin
      partial = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? mcand_q : '0)};
      prod_d  = {partial, prod_q[WIDTH-1:1]};
   end

   assign result_hi = result_hi_q;
`else
   logic unused_op_mul;
   assign unused_op_mul = op[OP_MUL];
   assign result_hi     = '0;
`endif

   // Drain is applied first so that a same-cycle accept overrides it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         c_out_q     <= 1'b0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
         ovf_q       <= 1'b0;
`ifdef ALU_MUL_EN
         result_hi_q <= '0;
         mcand_q     <= '0;
         prod_q      <= '0;
         cnt_q       <= '0;
`endif
      end else begin
         case (state_q)
            HOLD: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
`ifdef ALU_MUL_EN
            BUSY: begin
               prod_q <= prod_d;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH-1)) begin
                  state_q     <= HOLD;
                  out_valid_q <= 1'b1;
                  result_q    <= prod_d[WIDTH-1:0];
                  result_hi_q <= prod_d[2*WIDTH-1:WIDTH];
                  c_out_q     <= 1'b0;
                  ovf_q       <= 1'b0;
                  neg_q       <= prod_d[WIDTH-1];
                  zero_q      <= (prod_d == '0);
               end
            end
`endif
            IDLE: ;
            default: state_q <= IDLE;
         endcase

         if (accept) begin
`ifdef ALU_MUL_EN
            if (op[OP_MUL]) begin
               state_q     <= BUSY;
               out_valid_q <= 1'b0;
               mcand_q     <= x;
               prod_q      <= {{WIDTH{1'b0}}, y};
               cnt_q       <= '0;
            end else begin
               result_hi_q <= '0;
`else
            begin
`endif
               state_q     <= HOLD;
               out_valid_q <= 1'b1;
               result_q    <= core_res;
               c_out_q     <= core_c;
               ovf_q       <= core_v;
               neg_q       <= core_res[WIDTH-1];
               zero_q      <= (core_res == '0);
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign c_out     = c_out_q;
   assign zero      = zero_q;
   assign neg       = neg_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe (WIDTH=8), directed vectors
//   plus randomized traffic against an arithmetic reference model.
//   Multiply coverage is compiled in when ALU_MUL_EN is defined.
`timescale 1ns/1ps
module tb_alu_pipe;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic [4:0]   op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [W-1:0] result_hi;
   logic         c_out;
   logic         zero;
   logic         neg;
   logic         ovf;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   typedef struct {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic         c;
      logic         z;
      logic         n;
      logic         v;
      bit           mul;
   } exp_t;

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .result_hi (result_hi),
      .c_out     (c_out),
      .zero      (zero),
      .neg       (neg),
      .ovf       (ovf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: integer arithmetic on operand values, signed range test for overflow.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] o);
      exp_t        e;
      int unsigned ua, ub, bb, s, mask;
      int          sa, sb, ss;
      longint unsigned p;
      ua = a; ub = b; mask = (1 << W) - 1;
      e.mul = 1'b0; e.hi = '0; e.c = 1'b0; e.v = 1'b0; e.res = '0;
      p = 0;
`ifdef ALU_MUL_EN
      if (o[4]) begin
         p     = longint'(ua) * longint'(ub);
         e.mul = 1'b1;
         e.res = W'(p);
         e.hi  = W'(p >> W);
      end else
`endif
      if (!o[3]) begin
         case (o[2:1])
            2'b00:   bb = 0;
            2'b01:   bb = ub;
            2'b10:   bb = mask - ub;
            default: bb = mask;
         endcase
         s     = ua + bb + int'(o[0]);
         e.res = W'(s);
         e.c   = (s > mask);
         sa    = (ua >= (1 << (W-1))) ? int'(ua) - (1 << W) : int'(ua);
         sb    = (bb >= (1 << (W-1))) ? int'(bb) - (1 << W) : int'(bb);
         ss    = sa + sb + int'(o[0]);
         e.v   = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
      end else begin
         case (o[1:0])
            2'b00:   e.res = a & b;
            2'b01:   e.res = a | b;
            2'b10:   e.res = a ^ b;
            default: e.res = ~a;
         endcase
      end
      e.z = (e.res == 0) && (e.hi == 0);
      e.n = e.res[W-1];
      return e;
   endfunction

   task automatic chk_out(input string tag, input exp_t e);
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_res"},   result,    e.res);
      check({tag, "_hi"},    result_hi, e.hi);
      check({tag, "_cout"},  c_out,     e.c);
      check({tag, "_zero"},  zero,      e.z);
      check({tag, "_neg"},   neg,       e.n);
      check({tag, "_ovf"},   ovf,       e.v);
   endtask

   // Called at a negedge; returns at the negedge where the result first shows.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] o,
                       input string tag, output exp_t e);
      int k;
      int lat;
      e = model(a, b, o);
      x = a; y = b; op = o; in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 64) begin
         @(negedge clk);
         k++;
      end
      if (k >= 64) check({tag, "_accept_timeout"}, 0, 1);
      @(negedge clk);
      in_valid = 1'b0;
      x = W'($urandom); y = W'($urandom); op = 5'($urandom);
      lat = 1;
      while (!out_valid && lat < 64) begin
         check({tag, "_busy_in_ready"}, in_ready, 0);
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, lat, e.mul ? W + 1 : 1);
      chk_out(tag, e);
   endtask

   task automatic stall(input int n, input exp_t e);
      out_ready = 1'b0;
      repeat (n) begin
         @(negedge clk);
         check("stall_in_ready", in_ready, 0);
         chk_out("stall", e);
      end
      out_ready = 1'b1;
   endtask

   task automatic chk_reset_state(input string tag);
      check({tag, "_in_ready"},  in_ready,  1);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_res"},       result,    0);
      check({tag, "_hi"},        result_hi, 0);
      check({tag, "_flags"},     {c_out, zero, neg, ovf}, 4'b0000);
   endtask

   initial begin
      exp_t         e;
      logic [W-1:0] a, b;
      logic [4:0]   o;
      logic [W-1:0] edge_vals [4];
      edge_vals[0] = 8'h00; edge_vals[1] = 8'hFF; edge_vals[2] = 8'h7F; edge_vals[3] = 8'h80;

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0; op = '0;
      repeat (3) @(negedge clk);
      chk_reset_state("reset");
      reset = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);

      // Directed vectors with literal expectations
      send(8'h7F, 8'h01, 5'b00010, "t1", e);
      check("t1_lit_res", result, 8'h80);
      check("t1_lit_flags", {c_out, ovf, neg, zero}, 4'b0110);

      send(8'h05, 8'h05, 5'b00101, "t2", e);
      check("t2_lit_res", result, 8'h00);
      check("t2_lit_flags", {c_out, ovf, zero}, 3'b101);

      send(8'hA5, 8'h0F, 5'b01010, "t3a", e);
      check("t3a_lit_res", result, 8'hAA);
      check("t3a_lit_cout", c_out, 0);

      // Hold the XOR result 3 cycles, then drain and refill in one clock
      stall(3, e);
      send(8'hA5, 8'h0F, 5'b01011, "t3b", e);
      check("t3b_lit_res", result, 8'h5A);

`ifdef ALU_MUL_EN
      send(8'hFF, 8'hFF, 5'b10000, "t5", e);
      check("t5_lit_hi", result_hi, 8'hFE);
      check("t5_lit_res", result, 8'h01);
`endif

      // Randomized traffic with boundary operands, stalls and idle gaps
      for (int i = 0; i < 150; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         o = 5'($urandom);
         if ($urandom_range(0, 3) == 0) a = edge_vals[$urandom_range(0, 3)];
         if ($urandom_range(0, 3) == 0) b = edge_vals[$urandom_range(0, 3)];
         send(a, b, o, "rnd", e);
         if ($urandom_range(0, 3) == 0) stall(int'($urandom_range(1, 3)), e);
         if ($urandom_range(0, 4) == 0) begin
            @(negedge clk);
            check("gap_out_valid", out_valid, 0);
            check("gap_in_ready", in_ready, 1);
         end
      end

      // Reset in the middle of an operation
`ifdef ALU_MUL_EN
      x = 8'hFF; y = 8'hFF; op = 5'b10000; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("t6_busy_in_ready", in_ready, 0);
      repeat (3) @(negedge clk);
`else
      send(8'h12, 8'h34, 5'b00010, "t6_pre", e);
      out_ready = 1'b0;
      @(negedge clk);
`endif
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk_reset_state("t6_rst");
      out_ready = 1'b1;
      send(8'h80, 8'h80, 5'b00010, "post_rst", e);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
